// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter: round-robin two-port arbiter/sequencer for the 1 MiB dmem.   |
// | Optional macro DMEM_ARBITER_BOUNDS_CHECK_EN rejects out-of-range accesses. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic        r0_req_write,
  input  logic        r0_req_byte,
  input  logic [31:0] r0_req_addr,
  input  logic [31:0] r0_req_wdata,
  output logic        r0_rsp_valid,
  output logic [31:0] r0_rsp_rdata,
  output logic        r0_rsp_err,

  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic        r1_req_write,
  input  logic        r1_req_byte,
  input  logic [31:0] r1_req_addr,
  input  logic [31:0] r1_req_wdata,
  output logic        r1_rsp_valid,
  output logic [31:0] r1_rsp_rdata,
  output logic        r1_rsp_err,

  output logic        mem_write_word_en,
  output logic        mem_write_byte_en,
  output logic        mem_read_word_en,
  output logic        mem_read_byte_en,
  output logic [31:0] mem_write_word_address,
  output logic [31:0] mem_write_byte_address,
  output logic [31:0] mem_read_word_address,
  output logic [31:0] mem_read_byte_address,
  output logic [31:0] mem_write_word_data,
  output logic [7:0]  mem_write_byte_data,
  input  logic [31:0] mem_read_word_data,
  input  logic [7:0]  mem_read_byte_data
);

`ifdef DMEM_ARBITER_BOUNDS_CHECK_EN
  localparam logic c_check_en = 1'b1;
`else
  localparam logic c_check_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_id;
  logic        r_write;
  logic        r_byte;
  logic        r_oob;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_idle;
  logic        w_hs;
  logic        w_sel_write;
  logic        w_sel_byte;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [32:0] w_last_byte;
  logic        w_oob;
  logic [31:0] w_rdata;
  logic        w_rsp;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    w_gnt0      = r0_req_valid & (~r1_req_valid | r_last);
    w_gnt1      = r1_req_valid & (~r0_req_valid | ~r_last);
    w_idle      = rst_n & (r_state == S_IDLE);
    w_hs        = w_idle & (w_gnt0 | w_gnt1);
    w_sel_write = w_gnt1 ? r1_req_write : r0_req_write;
    w_sel_byte  = w_gnt1 ? r1_req_byte  : r0_req_byte;
    w_sel_addr  = w_gnt1 ? r1_req_addr  : r0_req_addr;
    w_sel_wdata = w_gnt1 ? r1_req_wdata : r0_req_wdata;
    // 33-bit sum so a word access near 4 GiB cannot wrap into range.
    w_last_byte = {1'b0, w_sel_addr} + (w_sel_byte ? 33'd0 : 33'd3);
    w_oob       = c_check_en & (w_last_byte >= 33'(MEM_BYTES));
  end

  assign r0_req_ready = w_idle & w_gnt0;
  assign r1_req_ready = w_idle & w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_oob   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_id    <= w_gnt1;
        r_last  <= w_gnt1;
        r_write <= w_sel_write;
        r_byte  <= w_sel_byte;
        r_oob   <= w_oob;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_write_word_en = 1'b0;
    mem_write_byte_en = 1'b0;
    mem_read_word_en  = 1'b0;
    mem_read_byte_en  = 1'b0;
    if (r_state == S_ACCESS && !r_oob) begin
      mem_write_word_en = r_write  & ~r_byte;
      mem_write_byte_en = r_write  &  r_byte;
      mem_read_word_en  = ~r_write & ~r_byte;
      mem_read_byte_en  = ~r_write &  r_byte;
    end
  end

  assign mem_write_word_address = r_addr;
  assign mem_write_byte_address = r_addr;
  assign mem_read_word_address  = r_addr;
  assign mem_read_byte_address  = r_addr;
  assign mem_write_word_data    = r_wdata;
  assign mem_write_byte_data    = r_wdata[7:0];

  // Read data is registered by the memory, so it is valid during RESP.
  always_comb begin
    w_rsp = (r_state == S_RESP);
    if (r_oob || r_write) w_rdata = 32'd0;
    else if (r_byte)      w_rdata = {24'd0, mem_read_byte_data};
    else                  w_rdata = mem_read_word_data;
  end

  assign r0_rsp_valid = w_rsp & ~r_id;
  assign r1_rsp_valid = w_rsp &  r_id;
  assign r0_rsp_rdata = r0_rsp_valid ? w_rdata : 32'd0;
  assign r1_rsp_rdata = r1_rsp_valid ? w_rdata : 32'd0;
  assign r0_rsp_err   = r0_rsp_valid & r_oob;
  assign r1_rsp_err   = r1_rsp_valid & r_oob;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter: directed vector bench for dmem_arbiter with a memory model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        r0_req_valid, r0_req_ready, r0_req_write, r0_req_byte;
  logic [31:0] r0_req_addr, r0_req_wdata, r0_rsp_rdata;
  logic        r0_rsp_valid, r0_rsp_err;
  logic        r1_req_valid, r1_req_ready, r1_req_write, r1_req_byte;
  logic [31:0] r1_req_addr, r1_req_wdata, r1_rsp_rdata;
  logic        r1_rsp_valid, r1_rsp_err;
  logic        mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en;
  logic [31:0] mem_write_word_address, mem_write_byte_address;
  logic [31:0] mem_read_word_address, mem_read_byte_address;
  logic [31:0] mem_write_word_data;
  logic [7:0]  mem_write_byte_data;
  logic [31:0] mem_read_word_data = 32'd0;
  logic [7:0]  mem_read_byte_data = 8'd0;

  dmem_arbiter #(.MEM_BYTES(1048576)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_write(r0_req_write), .r0_req_byte(r0_req_byte),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_write(r1_req_write), .r1_req_byte(r1_req_byte),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
    .mem_write_word_en(mem_write_word_en), .mem_write_byte_en(mem_write_byte_en),
    .mem_read_word_en(mem_read_word_en), .mem_read_byte_en(mem_read_byte_en),
    .mem_write_word_address(mem_write_word_address),
    .mem_write_byte_address(mem_write_byte_address),
    .mem_read_word_address(mem_read_word_address),
    .mem_read_byte_address(mem_read_byte_address),
    .mem_write_word_data(mem_write_word_data), .mem_write_byte_data(mem_write_byte_data),
    .mem_read_word_data(mem_read_word_data), .mem_read_byte_data(mem_read_byte_data)
  );

  // Little-endian byte memory, 1 MiB wrap, word accesses ignore addr[1:0].
  logic [7:0] mem [int];

  function automatic logic [7:0] mrd(input logic [31:0] a);
    int k;
    k = int'({12'd0, a[19:0]});
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  always @(posedge clk) begin
    logic [31:0] wb;
    if (mem_write_word_en) begin
      wb = {12'd0, mem_write_word_address[19:2], 2'b00};
      for (int i = 0; i < 4; i++) mem[int'(wb) + i] = mem_write_word_data[8*i +: 8];
    end
    if (mem_write_byte_en) mem[int'({12'd0, mem_write_byte_address[19:0]})] = mem_write_byte_data;
    if (mem_read_word_en) begin
      wb = {12'd0, mem_read_word_address[19:2], 2'b00};
      mem_read_word_data <= {mrd(wb + 32'd3), mrd(wb + 32'd2), mrd(wb + 32'd1), mrd(wb)};
    end
    if (mem_read_byte_en) mem_read_byte_data <= mrd(mem_read_byte_address);
  end

  logic [3:0] en;
  logic       all_zero;
  assign en = {mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en};
  assign all_zero = ({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
                      r0_rsp_rdata, r1_rsp_rdata, r0_rsp_err, r1_rsp_err, en,
                      mem_write_word_address, mem_write_byte_address,
                      mem_read_word_address, mem_read_byte_address,
                      mem_write_word_data, mem_write_byte_data} == '0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic        wr;
    logic        by;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic set_req(input logic id, input logic v, input logic wr, input logic by,
                         input logic [31:0] a, input logic [31:0] d);
    if (id) begin
      r1_req_valid = v; r1_req_write = wr; r1_req_byte = by; r1_req_addr = a; r1_req_wdata = d;
    end else begin
      r0_req_valid = v; r0_req_write = wr; r0_req_byte = by; r0_req_addr = a; r0_req_wdata = d;
    end
  endtask

  // Called at a negedge with the arbiter idle; returns at the T+3 negedge.
  task automatic run_vec(input vec_t v);
    logic [3:0] exp_en;
    int n;
    set_req(v.id, 1'b1, v.wr, v.by, v.addr, v.wdata);
    #1;
    n = 0;
    while (!(v.id ? r1_req_ready : r0_req_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_wait", n < 10, 1);
    chk("other_ready_low", v.id ? r0_req_ready : r1_req_ready, 0);
    @(posedge clk); #1;
    set_req(v.id, 1'b0, v.wr, v.by, v.addr, v.wdata);
    @(negedge clk);
    exp_en = v.exp_err ? 4'b0000 : v.wr ? (v.by ? 4'b0100 : 4'b1000) : (v.by ? 4'b0001 : 4'b0010);
    chk("access_enable", en, exp_en);
    chk("access_addr", {mem_write_word_address, mem_write_byte_address,
                        mem_read_word_address, mem_read_byte_address}, {4{v.addr}});
    chk("access_wdata", {mem_write_word_data, mem_write_byte_data}, {v.wdata, v.wdata[7:0]});
    chk("access_ready_low", {r0_req_ready, r1_req_ready}, 0);
    @(negedge clk);
    chk("resp_valid", {r1_rsp_valid, r0_rsp_valid}, v.id ? 2'b10 : 2'b01);
    chk("resp_rdata", v.id ? r1_rsp_rdata : r0_rsp_rdata, v.exp_rdata);
    chk("resp_err", v.id ? r1_rsp_err : r0_rsp_err, v.exp_err);
    chk("resp_enable_low", en, 0);
    @(negedge clk);
    chk("after_resp_quiet", {r1_rsp_valid, r0_rsp_valid, en}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    logic exp_id;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0203, 32'hFFFF_FFA5, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'hA522_3344, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h0000_0000, 32'h0000_00A5, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0201, 32'h0000_0000, 32'h0000_0033, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h000F_FFFC, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h000F_FFFC, 32'h0000_0000, 32'h1234_5678, 1'b0};
`ifdef DMEM_ARBITER_BOUNDS_CHECK_EN
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h000F_FFFE, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0010_0000, 32'h0000_00C3, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
`else
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h000F_FFFE, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0010_0000, 32'h0000_00C3, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_00C3, 1'b0};
`endif
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h000F_FFFF, 32'h0000_0000, 32'h0000_0012, 1'b0};

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_all_zero", all_zero, 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Reset while a load is in ACCESS: outputs clear at once, no response follows.
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
    #1;
    chk("rst_seq_ready", r0_req_ready, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
    @(negedge clk);
    chk("rst_seq_access_en", en, 4'b0010);
    #2;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_all_zero", all_zero, 1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (r0_rsp_valid || r1_rsp_valid || en != 4'd0) cnt++;
    end
    chk("rst_no_ghost_resp", cnt, 0);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'd0);
    #1;
    chk("rst_tie_to_r0", {r1_req_ready, r0_req_ready}, 2'b01);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_tie_rdata", r0_rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // Round-robin under continuous contention, starting from the reset pointer.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'd0);
    exp_id = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n = 0;
      while (!(r0_req_ready || r1_req_ready) && n < 10) begin
        @(negedge clk); #1; n++;
      end
      chk("rr_grant", {r1_req_ready, r0_req_ready}, exp_id ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("rr_busy_ready", {r1_req_ready, r0_req_ready}, 0);
      @(negedge clk);
      chk("rr_resp_owner", {r1_rsp_valid, r0_rsp_valid}, exp_id ? 2'b10 : 2'b01);
      chk("rr_rdata", exp_id ? r1_rsp_rdata : r0_rsp_rdata,
          exp_id ? 32'hA522_3344 : 32'hDEAD_BEEF);
      @(negedge clk);
      exp_id = ~exp_id;
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'd0);
    @(negedge clk);

    // r0 waits while r1 is mid-access, then gets exactly one handshake.
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 32'h203, 32'd0);
    #1;
    chk("stab_r1_ready", r1_req_ready, 1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h203, 32'd0);
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
    #1;
    chk("stab_r0_wait_access", r0_req_ready, 0);
    @(negedge clk); #1;
    chk("stab_r0_wait_resp", r0_req_ready, 0);
    chk("stab_r1_rdata", r1_rsp_rdata, 32'h0000_00A5);
    @(negedge clk); #1;
    chk("stab_r0_ready_idle", r0_req_ready, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (r0_rsp_valid) cnt++;
    end
    chk("stab_one_resp", cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
